// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and line levels common to TX and RX.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // True for the states in which a frame is on the wire and bit timing runs.
    function automatic logic is_busy_state(input tx_state_t s);
        return (s == START) || (s == DATA) || (s == STOP);
    endfunction

endpackage

// File: rtl/uart_tx_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit period. The flag is registered alongside the count so that
// it always equals (count == CLKS_PER_BIT-1) without a combinational decode.
module uart_tx_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic rollover_flag
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] NEXT_LAST = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [CW-1:0] count_r;
    logic          flag_r;

    // Count within the bit period; clear has priority, hold when disabled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= '0;
            flag_r  <= 1'b0;
        end else if (clr) begin
            count_r <= '0;
            flag_r  <= 1'b0;
        end else if (en) begin
            if (count_r == LAST) begin
                count_r <= '0;
                flag_r  <= 1'b0;
            end else begin
                count_r <= count_r + ONE;
                flag_r  <= (count_r == NEXT_LAST);
            end
        end else begin
            count_r <= count_r;
            flag_r  <= flag_r;
        end
    end

    assign rollover_flag = flag_r;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, STOP_BITS stop bits,
// each bit CLKS_PER_BIT clocks. All outputs come straight from flops; their next
// values are decoded from the next state so the line changes on the same edge
// the FSM does.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);

    tx_state_t            state_r, state_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [BW-1:0]        bit_idx_r, bit_idx_s;
    logic [1:0]           stop_cnt_r, stop_cnt_s;
    logic                 tx_out_r, tx_out_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 timer_en_s, timer_clr_s;
    logic                 rollover_s;

    assign timer_en_s = is_busy_state(state_r);

    uart_tx_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .en            (timer_en_s),
        .clr           (timer_clr_s),
        .rollover_flag (rollover_s)
    );

    // Next-state, datapath and next-output decode for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        bit_idx_s   = bit_idx_r;
        stop_cnt_s  = stop_cnt_r;
        timer_clr_s = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (tx_start) begin
                    state_s     = START;
                    shift_s     = tx_data;
                    timer_clr_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (rollover_s) begin
                    state_s   = DATA;
                    bit_idx_s = '0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (rollover_s) begin
                    shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                    bit_idx_s = bit_idx_r + BIT_ONE;
                    if (bit_idx_r == LAST_BIT) begin
                        state_s    = STOP;
                        stop_cnt_s = 2'd0;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (rollover_s) begin
                    if (stop_cnt_r == LAST_STOP) begin
                        state_s = DONE;
                    end else begin
                        stop_cnt_s = stop_cnt_r + 2'd1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        case (state_s)
            START:   tx_out_s = UART_START_LEVEL;
            DATA:    tx_out_s = shift_s[0];
            default: tx_out_s = UART_IDLE_LEVEL;
        endcase
        busy_s = is_busy_state(state_s);
        done_s = (state_s == DONE);
    end

    // State, datapath and output registers; reset forces the line idle at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            bit_idx_r  <= '0;
            stop_cnt_r <= 2'd0;
            tx_out_r   <= UART_IDLE_LEVEL;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_idx_r  <= bit_idx_s;
            stop_cnt_r <= stop_cnt_s;
            tx_out_r   <= tx_out_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign tx_out  = tx_out_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: two instances (default and a 2/5/2 sweep).
// Stimulus pushes {data, expected first-start-bit cycle}; per-instance monitors
// detect frames on the line and compare every cycle against a frame built from
// the framing rules (start 0, data LSB-first, stop 1s, each bit C cycles).
module tb_uart_tx;

    localparam int CA = 10, DA = 8, SA = 1;
    localparam int CB = 2,  DB = 5, SB = 2;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_a, start_b;
    logic [7:0] data_a;
    logic [4:0] data_b;
    logic       out_a, busy_a, done_a;
    logic       out_b, busy_b, done_b;

    int     cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;
    bit     mon_en [2];
    frame_t q_a[$];
    frame_t q_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(CA), .DATA_BITS(DA), .STOP_BITS(SA)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .tx_start(start_a), .tx_data(data_a),
        .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx #(.CLKS_PER_BIT(CB), .DATA_BITS(DB), .STOP_BITS(SB)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .tx_start(start_b), .tx_data(data_b),
        .tx_out(out_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    function automatic int cpb(input int k);   return (k == 0) ? CA : CB; endfunction
    function automatic int nbits(input int k); return (k == 0) ? DA : DB; endfunction
    function automatic int nstop(input int k); return (k == 0) ? SA : SB; endfunction
    function automatic int flen(input int k);
        return (1 + nbits(k) + nstop(k)) * cpb(k);
    endfunction

    // Reference line level for bit slot 'pos' of a frame carrying d.
    function automatic logic level_at(input int k, input logic [7:0] d, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= nbits(k)) return d[pos-1];
        return 1'b1;
    endfunction

    function automatic logic get_out(input int k);  return (k == 0) ? out_a  : out_b;  endfunction
    function automatic logic get_busy(input int k); return (k == 0) ? busy_a : busy_b; endfunction
    function automatic logic get_done(input int k); return (k == 0) ? done_a : done_b; endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int k, input logic s, input logic [7:0] d);
        if (k == 0) begin
            start_a = s;
            data_a  = d;
        end else begin
            start_b = s;
            data_b  = d[4:0];
        end
    endtask

    // Monitor: idle-line checks, then full-frame comparison against the scoreboard.
    task automatic monitor(input int k);
        frame_t f;
        int     bad_at;
        bit     busy_ok;
        bit     aborted;
        bit     have;
        forever begin
            @(negedge clk);
            if (!n_rst || !mon_en[k]) continue;
            if (get_out(k) === 1'b1) begin
                check($sformatf("idle%0d_busy_done", k), {get_busy(k), get_done(k)}, 0);
            end else begin
                have = (k == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
                if (!have) begin
                    check($sformatf("unexpected_frame%0d", k), 1, 0);
                    repeat (flen(k)) @(negedge clk);
                    continue;
                end
                f = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                check($sformatf("start_cycle%0d_%02h", k, f.data), cyc, f.start);
                bad_at  = -1;
                busy_ok = 1'b1;
                aborted = 1'b0;
                for (int i = 0; i < flen(k); i++) begin
                    if (i > 0) @(negedge clk);
                    if (!n_rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (get_out(k) !== level_at(k, f.data, i / cpb(k)) && bad_at < 0) bad_at = i;
                    if (get_busy(k) !== 1'b1 || get_done(k) !== 1'b0) busy_ok = 1'b0;
                end
                if (aborted) begin
                    check($sformatf("reset_in_frame%0d", k), 1, 0);
                    continue;
                end
                check($sformatf("frame%0d_%02h_first_bad_cycle", k, f.data), bad_at, -1);
                check($sformatf("frame%0d_%02h_busy", k, f.data), busy_ok, 1);
                @(negedge clk);
                check($sformatf("frame%0d_%02h_done_busy_out", k, f.data),
                      {get_done(k), get_busy(k), get_out(k)}, 3'b101);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Single start pulse; expected first start-bit sample is the next cycle.
    task automatic send(input int k, input logic [7:0] d);
        frame_t f;
        @(negedge clk);
        drive(k, 1'b1, d);
        f.data  = (k == 0) ? d : (d & 8'h1F);
        f.start = cyc + 1;
        if (k == 0) q_a.push_back(f); else q_b.push_back(f);
        @(negedge clk);
        drive(k, 1'b0, 8'($urandom));
    endtask

    // Wait for busy low; while busy, scramble tx_data and optionally pulse tx_start.
    task automatic wait_idle(input int k, input bit noise);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!get_busy(k)) begin
                drive(k, 1'b0, 8'($urandom));
                break;
            end
            n = n + 1;
            if (n > 2000) begin
                check($sformatf("wait_idle_timeout%0d", k), 1, 0);
                break;
            end
            drive(k, noise && ($urandom_range(0, 7) == 0), 8'($urandom));
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_a"}, {out_a, busy_a, done_a}, 3'b100);
        check({name, "_b"}, {out_b, busy_b, done_b}, 3'b100);
    endtask

    initial begin
        frame_t f;
        int     s;
        int     t;
        n_rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);

        // Reset idle and hold after release.
        repeat (3) @(negedge clk);
        check_quiet("reset");
        n_rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_quiet("post_reset");
        end
        mon_en[0] = 1'b1;
        mon_en[1] = 1'b1;

        // Single frame A5.
        send(0, 8'hA5);
        wait_idle(0, 1'b0);
        repeat (4) @(negedge clk);

        // Busy-ignore: second request at frame cycle 40 is dropped.
        send(0, 8'h3C);
        repeat (39) @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF);
        wait_idle(0, 1'b0);
        repeat (30) @(negedge clk);

        // Back-to-back with tx_start held: second start follows the DONE cycle.
        @(negedge clk);
        drive(0, 1'b1, 8'h00);
        s = cyc;
        f.data = 8'h00; f.start = s + 1;                         q_a.push_back(f);
        f.data = 8'hFF; f.start = s + 1 + flen(0) + 1;           q_a.push_back(f);
        @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        repeat (flen(0) + 1) @(negedge clk);
        drive(0, 1'b0, 8'h5A);
        wait_idle(0, 1'b0);
        repeat (3) @(negedge clk);

        // Mid-frame reset: line goes high asynchronously, frame abandoned.
        mon_en[0] = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (34) @(negedge clk);
        check("pre_reset_line_low", out_a, 0);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_reset_out_busy_done", {out_a, busy_a, done_a}, 3'b100);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_quiet("after_mid_reset");
        end
        mon_en[0] = 1'b1;

        // Parameter sweep instance: 5'h13 -> 0,1,1,0,0,1,1,1 at 2 cycles/bit.
        send(1, 8'h13);
        wait_idle(1, 1'b0);
        repeat (3) @(negedge clk);

        // Randomized traffic on both instances with ignored mid-frame requests.
        for (int i = 0; i < 12; i++) begin
            wait_idle(0, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(0, 8'($urandom));
        end
        wait_idle(0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            wait_idle(1, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1, 8'($urandom));
        end
        wait_idle(1, 1'b1);

        // Drain scoreboard with a bounded wait.
        t = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && t < 5000) begin
            @(negedge clk);
            t = t + 1;
        end
        check("scoreboard_drained", q_a.size() + q_b.size(), 0);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
